// File: rtl/carregador_programa.sv
// Program loader: receives the program as a byte stream and writes big-endian
// 32-bit words into the instruction memory at word-aligned byte addresses.
module carregador_programa #(
   parameter int NUM_PALAVRAS = 13,
   parameter int LARGURA_END  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iniciar,
   input  logic                   finalizar,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valido,
   output logic                   byte_pronto,
   output logic                   mem_we,
   output logic [LARGURA_END-1:0] mem_endereco,
   output logic [31:0]            mem_dado,
   output logic                   cpu_hold,
   output logic                   ocupado,
   output logic                   concluido,
   output logic [7:0]             contagem_palavras
);

   typedef enum logic [1:0] {OCIOSO, RECEBE, ESCREVE, FIM} estado_t;

   localparam logic [7:0] ULTIMO = 8'(NUM_PALAVRAS - 1);

   estado_t     estado, proximo;
   logic [1:0]  cont_bytes;
   logic [7:0]  indice;
   logic [31:0] montagem;
   logic        fim_forcado;
   logic        aceita;
   logic        partida;

   assign aceita  = (estado == RECEBE) && byte_valido && !finalizar;
   assign partida = ((estado == OCIOSO) || (estado == FIM)) && iniciar;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:  if (iniciar) proximo = RECEBE;
         RECEBE: begin
            if (finalizar)
               proximo = (cont_bytes == 2'd0) ? FIM : ESCREVE;
            else if (byte_valido && (cont_bytes == 2'd3))
               proximo = ESCREVE;
         end
         ESCREVE: proximo = (fim_forcado || (indice == ULTIMO)) ? FIM : RECEBE;
         FIM:     if (iniciar) proximo = RECEBE;
         default: proximo = OCIOSO;
      endcase
   end

   // Assembly register is cleared after each write, so a word cut short by
   // finalizar already carries zeros in its missing low bytes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cont_bytes        <= 2'd0;
         indice            <= 8'd0;
         montagem          <= 32'd0;
         fim_forcado       <= 1'b0;
         contagem_palavras <= 8'd0;
      end else if (partida) begin
         cont_bytes        <= 2'd0;
         indice            <= 8'd0;
         montagem          <= 32'd0;
         fim_forcado       <= 1'b0;
         contagem_palavras <= 8'd0;
      end else if (estado == RECEBE) begin
         if (finalizar) begin
            if (cont_bytes != 2'd0) fim_forcado <= 1'b1;
         end else if (aceita) begin
            case (cont_bytes)
               2'd0:    montagem[31:24] <= byte_in;
               2'd1:    montagem[23:16] <= byte_in;
               2'd2:    montagem[15:8]  <= byte_in;
               default: montagem[7:0]   <= byte_in;
            endcase
            cont_bytes <= cont_bytes + 2'd1;
         end
      end else if (estado == ESCREVE) begin
         indice            <= indice + 8'd1;
         contagem_palavras <= contagem_palavras + 8'd1;
         cont_bytes        <= 2'd0;
         montagem          <= 32'd0;
      end
   end

   // Outputs decode from state and registers only; address/data are zero
   // outside the write cycle.
   assign byte_pronto  = (estado == RECEBE);
   assign mem_we       = (estado == ESCREVE);
   assign mem_endereco = mem_we ? LARGURA_END'({indice, 2'b00}) : '0;
   assign mem_dado     = mem_we ? montagem : 32'd0;
   assign ocupado      = (estado == RECEBE) || (estado == ESCREVE);
   assign cpu_hold     = ocupado;
   assign concluido    = (estado == FIM);

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: word assembly, gaps, padding,
// memory-full stop, async reset mid-load and ignored restart.
module tb_carregador_programa;

   localparam int NP = 13;

   logic        clk = 1'b0;
   logic        reset, iniciar, finalizar, byte_valido;
   logic [7:0]  byte_in;
   logic        byte_pronto, mem_we, cpu_hold, ocupado, concluido;
   logic [31:0] mem_endereco, mem_dado;
   logic [7:0]  contagem_palavras;

   int vetores = 0, miscompares = 0, n_escritas = 0, n0;

   carregador_programa #(.NUM_PALAVRAS(NP), .LARGURA_END(32)) dut (
      .clk(clk), .reset(reset), .iniciar(iniciar), .finalizar(finalizar),
      .byte_in(byte_in), .byte_valido(byte_valido), .byte_pronto(byte_pronto),
      .mem_we(mem_we), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
      .cpu_hold(cpu_hold), .ocupado(ocupado), .concluido(concluido),
      .contagem_palavras(contagem_palavras)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_we === 1'b1) n_escritas++;

   task automatic verifica1(input string tag, input logic obs, input logic esp);
      vetores++;
      assert (obs === esp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, esp);
      end
   endtask

   task automatic verifica32(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      vetores++;
      assert (obs === esp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, esp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulsa_iniciar();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   task automatic pulsa_finalizar();
      finalizar = 1'b1;
      tick();
      finalizar = 1'b0;
   endtask

   task automatic envia_byte(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) tick();
      byte_in     = b;
      byte_valido = 1'b1;
      tick();
      byte_valido = 1'b0;
   endtask

   // Sends a full word and checks the write appears right after the 4th byte.
   task automatic envia_palavra(input logic [31:0] w, input logic [31:0] end_esp,
                                input int gap, input string tag);
      envia_byte(w[31:24], gap);
      envia_byte(w[23:16], gap);
      envia_byte(w[15:8], gap);
      envia_byte(w[7:0], gap);
      verifica1({tag, " we"}, mem_we, 1'b1);
      verifica32({tag, " addr"}, mem_endereco, end_esp);
      verifica32({tag, " data"}, mem_dado, w);
      verifica1({tag, " pronto_in_write"}, byte_pronto, 1'b0);
      tick();
      verifica1({tag, " we_one_cycle"}, mem_we, 1'b0);
   endtask

   initial begin
      reset = 1'b1; iniciar = 1'b0; finalizar = 1'b0;
      byte_valido = 1'b0; byte_in = 8'h00;
      #1;
      verifica1("rst pronto", byte_pronto, 1'b0);
      verifica1("rst we", mem_we, 1'b0);
      verifica32("rst addr", mem_endereco, 32'h0);
      verifica32("rst data", mem_dado, 32'h0);
      verifica1("rst hold", cpu_hold, 1'b0);
      verifica1("rst ocupado", ocupado, 1'b0);
      verifica1("rst concluido", concluido, 1'b0);
      verifica32("rst contagem", 32'(contagem_palavras), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      verifica1("idle pronto", byte_pronto, 1'b0);

      // Back-to-back stream then finalizar on a word boundary
      n0 = n_escritas;
      pulsa_iniciar();
      verifica1("t1 pronto", byte_pronto, 1'b1);
      verifica1("t1 hold", cpu_hold, 1'b1);
      envia_palavra(32'h00500093, 32'h0, 0, "t1w0");
      envia_palavra(32'h00A00113, 32'h4, 0, "t1w1");
      pulsa_finalizar();
      verifica1("t1 concluido", concluido, 1'b1);
      verifica32("t1 contagem", 32'(contagem_palavras), 32'd2);
      verifica1("t1 hold_off", cpu_hold, 1'b0);
      verifica32("t1 n_writes", 32'(n_escritas - n0), 32'd2);

      // Same stream with 3-cycle gaps between bytes
      n0 = n_escritas;
      pulsa_iniciar();
      verifica1("t2 concluido_clr", concluido, 1'b0);
      verifica32("t2 contagem_clr", 32'(contagem_palavras), 32'd0);
      envia_palavra(32'h00500093, 32'h0, 3, "t2w0");
      envia_palavra(32'h00A00113, 32'h4, 3, "t2w1");
      tick(); tick();
      pulsa_finalizar();
      verifica1("t2 concluido", concluido, 1'b1);
      verifica32("t2 contagem", 32'(contagem_palavras), 32'd2);
      verifica32("t2 n_writes", 32'(n_escritas - n0), 32'd2);

      // Partial last word gets zero-padded
      n0 = n_escritas;
      pulsa_iniciar();
      envia_palavra(32'h11121314, 32'h0, 0, "t3w0");
      envia_byte(8'h15, 0);
      envia_byte(8'h16, 0);
      verifica1("t3 no_early_we", mem_we, 1'b0);
      pulsa_finalizar();
      verifica1("t3 pad we", mem_we, 1'b1);
      verifica32("t3 pad addr", mem_endereco, 32'h4);
      verifica32("t3 pad data", mem_dado, 32'h15160000);
      tick();
      verifica1("t3 concluido", concluido, 1'b1);
      verifica32("t3 contagem", 32'(contagem_palavras), 32'd2);
      verifica32("t3 n_writes", 32'(n_escritas - n0), 32'd2);

      // Fill the memory, then offer 4 extra bytes
      n0 = n_escritas;
      pulsa_iniciar();
      for (int i = 0; i < NP; i++)
         envia_palavra({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 32'(4*i), 0, "t4");
      verifica1("t4 concluido", concluido, 1'b1);
      byte_in = 8'hEE;
      byte_valido = 1'b1;
      for (int k = 0; k < 4; k++) begin
         verifica1("t4 extra pronto", byte_pronto, 1'b0);
         tick();
      end
      byte_valido = 1'b0;
      verifica1("t4 extra we", mem_we, 1'b0);
      verifica32("t4 contagem", 32'(contagem_palavras), 32'd13);
      verifica32("t4 n_writes", 32'(n_escritas - n0), 32'd13);

      // Async reset in the middle of word 1
      n0 = n_escritas;
      pulsa_iniciar();
      envia_palavra(32'hDEADBEEF, 32'h0, 0, "t5w0");
      envia_byte(8'hAA, 0);
      envia_byte(8'hBB, 0);
      #2 reset = 1'b1;
      #1;
      verifica1("t5 async pronto", byte_pronto, 1'b0);
      verifica1("t5 async hold", cpu_hold, 1'b0);
      verifica1("t5 async ocupado", ocupado, 1'b0);
      verifica32("t5 async contagem", 32'(contagem_palavras), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      verifica32("t5 n_writes", 32'(n_escritas - n0), 32'd1);
      pulsa_iniciar();
      envia_palavra(32'h01020304, 32'h0, 0, "t5restart");

      // iniciar while receiving is ignored
      envia_byte(8'hC1, 0);
      pulsa_iniciar();
      verifica1("t6 pronto", byte_pronto, 1'b1);
      verifica32("t6 contagem_kept", 32'(contagem_palavras), 32'd1);
      envia_byte(8'hC2, 0);
      envia_byte(8'hC3, 0);
      envia_byte(8'hC4, 0);
      verifica1("t6 we", mem_we, 1'b1);
      verifica32("t6 addr", mem_endereco, 32'h4);
      verifica32("t6 data", mem_dado, 32'hC1C2C3C4);
      tick();

      // finalizar wins over a byte offered in the same cycle
      n0 = n_escritas;
      byte_in = 8'h77; byte_valido = 1'b1; finalizar = 1'b1;
      tick();
      byte_valido = 1'b0; finalizar = 1'b0;
      verifica1("t7 concluido", concluido, 1'b1);
      verifica1("t7 pronto", byte_pronto, 1'b0);
      verifica1("t7 we", mem_we, 1'b0);
      tick();
      verifica32("t7 contagem", 32'(contagem_palavras), 32'd2);
      verifica32("t7 n_writes", 32'(n_escritas - n0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vetores, miscompares);
      $finish;
   end

endmodule
